// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the keyboard event FIFO arbiter.
// Also used where the event FIFO itself is instantiated.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int NUM_REQ_DEF       = 4;
  localparam int EVENT_WIDTH_DEF   = 8;
  localparam int FIFO_CAPACITY_DEF = 8;
  localparam int LEVEL_WIDTH_DEF   = 4;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_event_arbiter_if.sv
// Source-side request bus plus FIFO-side write/read strobes.
// slave is the arbiter, master is the surrounding logic.
interface fifo_event_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ     = NUM_REQ_DEF,
  parameter int EVENT_WIDTH = EVENT_WIDTH_DEF,
  parameter int LEVEL_WIDTH = LEVEL_WIDTH_DEF
) ();

  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ*EVENT_WIDTH-1:0] req_event;
  logic [NUM_REQ-1:0]             grant;
  logic                           host_rd;
  logic                           fifo_wr;
  logic [EVENT_WIDTH-1:0]         fifo_data;
  logic                           fifo_rd;
  logic [LEVEL_WIDTH-1:0]         fifo_level;
  logic                           fifo_full;

  modport slave (
    input  req, req_event, host_rd,
    output grant, fifo_wr, fifo_data,
    output fifo_rd, fifo_level, fifo_full
  );

  modport master (
    output req, req_event, host_rd,
    input  grant, fifo_wr, fifo_data,
    input  fifo_rd, fifo_level, fifo_full
  );

endinterface

// File: rtl/fifo_event_arbiter_rr_arbiter.sv
// Combinational round-robin picker: search starts one past ptr.
// Lower indices only win through the wrap of the search order.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int PTR_W   = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   index,
  output logic               any
);

  logic             found;
  logic [PTR_W-1:0] k;

  assign any = |req;

  // first pending source after ptr, wrapping modulo NUM_REQ
  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    k     = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      k = PTR_W'((int'(ptr) + off) % NUM_REQ);
      if (!found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        index    = k;
      end
    end
  end

endmodule

// File: rtl/fifo_event_arbiter.sv
// Shares the event FIFO write port among NUM_REQ sources and
// tracks a shadow occupancy so the flagless FIFO never overruns.
module fifo_event_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ       = NUM_REQ_DEF,
  parameter int EVENT_WIDTH   = EVENT_WIDTH_DEF,
  parameter int FIFO_CAPACITY = FIFO_CAPACITY_DEF,
  parameter int LEVEL_WIDTH   = LEVEL_WIDTH_DEF
) (
  input logic                clk,
  input logic                rst,
  fifo_event_arbiter_if.slave bus
);

  localparam int PTR_W = ptr_width(NUM_REQ);
  localparam logic [LEVEL_WIDTH-1:0] CAP =
    LEVEL_WIDTH'(FIFO_CAPACITY);

  state_t                 state;
  state_t                 state_n;
  logic                   launch;
  logic                   any_req;
  logic                   full;
  logic [PTR_W-1:0]       ptr;
  logic [PTR_W-1:0]       win_idx;
  logic [NUM_REQ-1:0]     win_grant;
  logic [EVENT_WIDTH-1:0] win_event;
  logic [NUM_REQ-1:0]     grant_q;
  logic                   wr_q;
  logic [EVENT_WIDTH-1:0] data_q;
  logic                   rd_q;
  logic                   rd_prev;
  logic                   inc;
  logic                   dec;
  logic [LEVEL_WIDTH-1:0] level;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req   (bus.req),
    .ptr   (ptr),
    .grant (win_grant),
    .index (win_idx),
    .any   (any_req)
  );

  assign full           = (level == CAP);
  assign bus.grant      = grant_q;
  assign bus.fifo_wr    = wr_q;
  assign bus.fifo_data  = data_q;
  assign bus.fifo_rd    = rd_q;
  assign bus.fifo_level = level;
  assign bus.fifo_full  = full;

  // event word of the winning source
  always_comb begin
    win_event = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == PTR_W'(i)) begin
        win_event = bus.req_event[i*EVENT_WIDTH +: EVENT_WIDTH];
      end
    end
  end

  // write sequencer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // one write per three cycles; grant only while not full
  always_comb begin
    state_n = state;
    launch  = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_req && !full) begin
          state_n = WR;
          launch  = 1'b1;
        end
      end
      WR:      state_n = HOLD;
      HOLD:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // grant/strobe pulse and event latch held until the FIFO commits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      ptr     <= PTR_W'(NUM_REQ - 1);
    end else begin
      grant_q <= launch ? win_grant : '0;
      wr_q    <= launch;
      if (launch) begin
        data_q <= win_event;
        ptr    <= win_idx;
      end
    end
  end

  // host read is registered, then edge-detected against itself
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q    <= 1'b0;
      rd_prev <= 1'b0;
    end else begin
      rd_q    <= bus.host_rd;
      rd_prev <= rd_q;
    end
  end

  assign inc = (state == HOLD);
  assign dec = rd_q && !rd_prev && (level != '0);

  // shadow occupancy; write commit and read cancel when coincident
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= '0;
    end else if (inc && !dec) begin
      level <= level + 1'b1;
    end else if (dec && !inc) begin
      level <= level - 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_event_arbiter.sv
// Directed bench for fifo_event_arbiter with a queue-based FIFO
// model checked against the DUT on every falling clock edge.
module tb_fifo_event_arbiter;
  import fifo_arb_pkg::*;

  localparam int NR  = 4;
  localparam int EW  = 8;
  localparam int CAP = 8;
  localparam int LW  = 4;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  fifo_event_arbiter_if #(
    .NUM_REQ(NR), .EVENT_WIDTH(EW), .LEVEL_WIDTH(LW)
  ) bus ();

  fifo_event_arbiter #(
    .NUM_REQ(NR), .EVENT_WIDTH(EW),
    .FIFO_CAPACITY(CAP), .LEVEL_WIDTH(LW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // event sources: per-source list, next event presented after a grant
  logic [EW-1:0] ev_mem [NR][DEPTH];
  int head [NR];
  int tail [NR];
  int gcnt [NR];

  task automatic post(input int i, input logic [EW-1:0] ev);
    ev_mem[i][tail[i]] = ev;
    tail[i]++;
  endtask

  initial begin
    logic [NR-1:0]    r;
    logic [NR*EW-1:0] e;
    for (int i = 0; i < NR; i++) begin
      head[i] = 0; tail[i] = 0; gcnt[i] = 0;
    end
    bus.req = '0;
    bus.req_event = '0;
    forever begin
      @(negedge clk);
      r = '0;
      e = '0;
      for (int i = 0; i < NR; i++) begin
        if (rst) head[i] = tail[i];
        else if (bus.grant[i] && head[i] < tail[i]) begin
          head[i]++;
          gcnt[i]++;
        end
        if (head[i] < tail[i]) begin
          r = r | (NR'(1) << i);
          e = e | ((NR*EW)'(ev_mem[i][head[i]]) << (i*EW));
        end
      end
      bus.req = r;
      bus.req_event = e;
    end
  end

  // model: FIFO contents as a queue, writes spaced by a cycle count
  int            since;
  int            mptr;
  logic [EW-1:0] mq [$];
  logic [EW-1:0] m_data;
  logic [EW-1:0] m_out;
  logic [NR-1:0] m_grant;
  logic          m_wr;
  logic          m_rd;
  logic          m_rd_prev;

  initial begin
    int lvl0, win, k;
    bit rise;
    logic [NR-1:0] rq;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        since = 3; mptr = NR - 1; mq.delete();
        m_data = '0; m_out = '0; m_grant = '0;
        m_wr = 1'b0; m_rd = 1'b0; m_rd_prev = 1'b0;
      end else begin
        lvl0 = mq.size();
        rise = m_rd && !m_rd_prev;
        m_rd_prev = m_rd;
        m_rd = bus.host_rd;
        if (rise) begin
          if (mq.size() > 0) m_out = mq.pop_front();
          else m_out = '0;
        end
        if (since == 2) mq.push_back(m_data);
        win = -1;
        rq = bus.req;
        if (since >= 3 && lvl0 < CAP) begin
          for (int off = 1; off <= NR; off++) begin
            k = (mptr + off) % NR;
            if (win < 0 && ((rq >> k) & NR'(1)) != '0) win = k;
          end
        end
        if (win >= 0) begin
          m_grant = NR'(1) << win;
          m_wr = 1'b1;
          m_data = EW'(bus.req_event >> (win*EW));
          mptr = win;
          since = 1;
        end else begin
          m_grant = '0;
          m_wr = 1'b0;
          if (since < 3) since++;
        end
      end
    end
  end

  // per-cycle comparison against the model
  initial begin
    logic prev_wr;
    prev_wr = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) prev_wr = 1'b0;
      else begin
        check("grant", bus.grant, m_grant);
        check("fifo_wr", bus.fifo_wr, m_wr);
        check("fifo_data", bus.fifo_data, m_data);
        check("fifo_rd", bus.fifo_rd, m_rd);
        check("fifo_level", bus.fifo_level, mq.size());
        check("fifo_full", bus.fifo_full, mq.size() == CAP);
        check("wr_gap", bus.fifo_wr & prev_wr, 0);
        prev_wr = bus.fifo_wr;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_grant(output int n,
                            input logic [NR-1:0] exp,
                            input string name);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (bus.grant == '0 && n < 8);
    check(name, bus.grant, exp);
  endtask

  task automatic wait_level(input int lv, input int budget,
                            input string name);
    int n;
    n = 0;
    while (bus.fifo_level != LW'(lv) && n < budget) begin
      tick(1);
      n++;
    end
    check(name, bus.fifo_level, lv);
  endtask

  task automatic read_one(input logic [EW-1:0] exp,
                          input string name);
    bus.host_rd = 1'b1;
    tick(2);
    bus.host_rd = 1'b0;
    tick(2);
    check(name, m_out, exp);
  endtask

  initial begin
    int n, g1;
    logic [NR-1:0] rr_exp [5];
    bus.host_rd = 1'b0;
    rst = 1'b1;
    #12;
    check("rst_grant", bus.grant, 0);
    check("rst_wr", bus.fifo_wr, 0);
    check("rst_data", bus.fifo_data, 0);
    check("rst_rd", bus.fifo_rd, 0);
    check("rst_level", bus.fifo_level, 0);
    check("rst_full", bus.fifo_full, 0);
    tick(1);
    rst = 1'b0;

    // single event
    post(2, 8'h5A);
    wait_grant(n, 4'b0100, "t1_grant");
    check("t1_latency", n, 1);
    check("t1_wr", bus.fifo_wr, 1);
    check("t1_data", bus.fifo_data, 8'h5A);
    tick(1);
    check("t1_wr_low", bus.fifo_wr, 0);
    check("t1_data_wr", bus.fifo_data, 8'h5A);
    check("t1_level0", bus.fifo_level, 0);
    tick(1);
    check("t1_level1", bus.fifo_level, 1);
    check("t1_data_hold", bus.fifo_data, 8'h5A);
    read_one(8'h5A, "t1_read");
    check("t1_level_rd", bus.fifo_level, 0);

    // round robin from a fresh pointer
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    post(0, 8'h10); post(1, 8'h11);
    post(2, 8'h12); post(3, 8'h13);
    post(0, 8'h14);
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int j = 0; j < 5; j++) begin
      wait_grant(n, rr_exp[j], "t2_order");
      if (j > 0) check("t2_spacing", n, 3);
    end
    wait_level(5, 4, "t2_level");
    read_one(8'h10, "t2_rd0");
    read_one(8'h11, "t2_rd1");
    read_one(8'h12, "t2_rd2");
    read_one(8'h13, "t2_rd3");
    read_one(8'h14, "t2_rd4");
    check("t2_empty", bus.fifo_level, 0);

    // full back-pressure
    for (int j = 0; j < 8; j++) post(0, EW'(8'h20 + j));
    wait_level(8, 40, "t3_fill");
    check("t3_full", bus.fifo_full, 1);
    g1 = gcnt[1];
    post(1, 8'h55);
    tick(6);
    check("t3_nogrant", gcnt[1], g1);
    check("t3_level_held", bus.fifo_level, 8);
    bus.host_rd = 1'b1;
    tick(2);
    check("t3_lvl7", bus.fifo_level, 7);
    check("t3_first", m_out, 8'h20);
    wait_grant(n, 4'b0010, "t3_grant");
    check("t3_resume", n, 1);
    tick(2);
    check("t3_refill", bus.fifo_level, 8);
    bus.host_rd = 1'b0;
    tick(2);
    for (int j = 1; j < 8; j++) read_one(EW'(8'h20 + j), "t3_drain");
    read_one(8'h55, "t3_last");
    check("t3_empty", bus.fifo_level, 0);

    // read edge coincident with write commit
    post(3, 8'h30); post(3, 8'h31); post(3, 8'h32);
    wait_level(3, 20, "t4_fill");
    post(2, 8'h40);
    wait_grant(n, 4'b0100, "t4_grant");
    bus.host_rd = 1'b1;
    tick(2);
    check("t4_simul", bus.fifo_level, 3);
    check("t4_out", m_out, 8'h30);
    tick(3);
    check("t4_steady", bus.fifo_level, 3);
    bus.host_rd = 1'b0;
    tick(2);
    read_one(8'h31, "t4_rd1");
    read_one(8'h32, "t4_rd2");
    read_one(8'h40, "t4_rd3");

    // reads from empty
    for (int j = 0; j < 3; j++) begin
      read_one(8'h00, "t5_empty_out");
      check("t5_empty_level", bus.fifo_level, 0);
    end

    // reset while a write is in flight
    post(1, 8'h65);
    wait_level(1, 8, "t6_pre");
    post(2, 8'h66);
    wait_grant(n, 4'b0100, "t6_grant");
    check("t6_wr", bus.fifo_wr, 1);
    rst = 1'b1;
    #1;
    check("t6_rst_grant", bus.grant, 0);
    check("t6_rst_wr", bus.fifo_wr, 0);
    check("t6_rst_data", bus.fifo_data, 0);
    check("t6_rst_rd", bus.fifo_rd, 0);
    check("t6_rst_level", bus.fifo_level, 0);
    check("t6_rst_full", bus.fifo_full, 0);
    tick(2);
    rst = 1'b0;
    post(3, 8'h61);
    wait_grant(n, 4'b1000, "t6_grant3");
    check("t6_latency", n, 1);
    tick(2);
    check("t6_level", bus.fifo_level, 1);
    read_one(8'h61, "t6_read");
    check("t6_empty", bus.fifo_level, 0);

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, errors=%0d",
             errors);
    $fatal(1, "watchdog timeout");
  end

endmodule

// File: doc/fifo_event_arbiter.md
Name: fifo_event_arbiter

Overview:
- Shares the single write port of the keyboard event FIFO between NUM_REQ event sources, such as key-scan and encoder blocks.
- Round-robin arbitration between sources.
- Generates the rising-edge write/read handshake the FIFO expects.
- Keeps a shadow occupancy count so the FIFO, which has no full flag, is never overrun. Sits between the event sources and the FIFO instance.

Parameters:
NUM_REQ, 4, number of event sources
EVENT_WIDTH, 8, event word width; must equal FIFO event width
FIFO_CAPACITY, 8, FIFO depth in events
LEVEL_WIDTH, 4, occupancy counter width; must hold 0..FIFO_CAPACITY

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req  in  NUM_REQ  per-source event pending; level signal, held until granted
req_event  in  NUM_REQ*EVENT_WIDTH  per-source event word; source i occupies bits [i*EVENT_WIDTH +: EVENT_WIDTH]; stable while req[i]=1
grant  out  NUM_REQ  one-hot, one-cycle acknowledge; source drops or updates req/event next cycle
host_rd  in  1  host read request (level); each rising edge consumes one event
fifo_wr  out  1  to FIFO write input
fifo_data  out  EVENT_WIDTH  to FIFO data input
fifo_rd  out  1  to FIFO read input; registered copy of host_rd
fifo_level  out  LEVEL_WIDTH  shadow occupancy
fifo_full  out  1  fifo_level == FIFO_CAPACITY

Behaviour:
- Reset values: grant=0, fifo_wr=0, fifo_data=0, fifo_rd=0, fifo_level=0, fifo_full=0. FSM=IDLE, round-robin pointer=NUM_REQ-1 (source 0 has first priority), host_rd edge register=0.
- FIFO timing: the FIFO samples fifo_wr, makes an internal strobe on the next edge, then writes fifo_data on the edge after that. fifo_wr must be low for at least one edge between writes.
- FSM states IDLE, WR, HOLD.
  - IDLE -> WR when any req and fifo_full=0. On this edge: latch the winner's event into fifo_data; set fifo_wr=1; set grant[winner]=1; pointer=winner.
  - WR -> HOLD unconditionally: fifo_wr=0, grant=0, fifo_data held.
  - HOLD -> IDLE unconditionally: fifo_data held through this edge, where the FIFO commits the write; fifo_level increments on this edge.
  - Throughput is 1 event per 3 cycles. fifo_wr is high for exactly 1 cycle.
- Arbitration: round-robin, searching from pointer+1 upward with wrap modulo NUM_REQ. Lower index wins only via search order. Evaluated in IDLE only.
- Read side:
  - fifo_rd is host_rd registered, 1 cycle latency.
  - A rising edge of fifo_rd (registered vs previous) with fifo_level>0 decrements the level.
  - A rising edge at level 0 leaves the level at 0; the FIFO outputs 0.
- Simultaneous increment (HOLD exit) and decrement on the same edge: level unchanged.
- Full: no grant while fifo_full=1. Requests stay pending (back-pressure, no drop). Arbitration resumes in the first IDLE cycle after the level falls.
- Occupancy never exceeds FIFO_CAPACITY, since at most one write is in flight and it is counted before the next grant.
- Reset mid-operation: everything returns to reset values immediately. An in-flight event is lost; the FIFO shares rst, so the level stays consistent.
- Widths: level arithmetic is unsigned in LEVEL_WIDTH with no wrap, enforced by the guards above.

Decomposition:
- Shared package fifo_arb_pkg holds the FSM state encoding constants (IDLE, WR, HOLD) and the default EVENT_WIDTH/FIFO_CAPACITY, shared with the FIFO instantiation.
- One sub-module, rr_arbiter: combinational one-hot round-robin picker (inputs req, pointer; outputs onehot grant and index). Registers stay in fifo_event_arbiter.

Test Plan:
- Single event: req[2]=1 with event 0x5A in IDLE, level 0 -> grant[2] and fifo_wr high 1 cycle later; fifo_data=0x5A held 3 cycles; fifo_level=1 after HOLD; host_rd pulse -> FIFO output 0x5A, level 0.
- Round robin: req=4'b1111 held, events 0x10..0x13 -> grants in order 0,1,2,3,0 at 3-cycle spacing; fifo_wr never high on consecutive cycles.
- Full back-pressure: 8 writes -> fifo_full=1, further req[1] gets no grant. One host_rd rising edge -> level 7, grant[1] in the next IDLE, level returns to 8.
- Simultaneous: level 3; host_rd edge registered on the same edge as HOLD exit -> level stays 3.
- Empty read: level 0, host_rd toggled 3 times -> level stays 0, no underflow, FIFO outputs 0x00.
- Reset mid-WR: assert rst while fifo_wr=1 -> all outputs 0 immediately. After release, req[3] gets grant[3] first with pointer reset, and fifo_level counts from 0.
